otter_decode_stage: RTL and testbench

Pipelined OTTER instruction-decode stage with its ID/EX pipeline register. It turns a fetched RV32I instruction into the 4-bit ALU function code, operand selects, immediate and control bits consumed by the execute-stage ALU. It sits between fetch and execute. It owns the IF→ID valid/ready handshake, load-use hazard stalls, and flush/bubble insertion.

---
 rtl/otter_pkg.sv | 99 +++++++++
 rtl/otter_decode_stage_if.sv | 11 +
 rtl/otter_imm_gen.sv | 16 +
 rtl/otter_decode_stage.sv | 204 ++++++++++++++++++++
 tb/tb_otter_decode_stage.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/otter_pkg.sv
// Shared OTTER definitions: ALU function codes, operand/writeback selects,
// RV32I opcodes and the ID/EX register layout.
package otter_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_LUI  = 4'b1001,
    ALU_SRA  = 4'b1101
  } alu_fun_t;

  typedef enum logic [1:0] {
    OP1_RS1  = 2'd0,
    OP1_UIMM = 2'd1,
    OP1_PC   = 2'd2
  } op1_sel_t;

  typedef enum logic {
    OP2_RS2 = 1'b0,
    OP2_IMM = 1'b1
  } op2_sel_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [31:0] NOP_PC = 32'h0000_0000;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    alu_fun_t    alu_fun;
    op1_sel_t    op1_sel;
    op2_sel_t    op2_sel;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_we;
    wb_sel_t     wb_sel;
    logic        mem_re;
    logic        mem_we;
    logic [2:0]  mem_size;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic        illegal;
  } id_reg_t;

  localparam id_reg_t ID_BUBBLE = '{
    valid:    1'b0,
    pc:       NOP_PC,
    alu_fun:  ALU_ADD,
    op1_sel:  OP1_RS1,
    op2_sel:  OP2_RS2,
    imm:      32'h0,
    rs1:      5'd0,
    rs2:      5'd0,
    rd:       5'd0,
    reg_we:   1'b0,
    wb_sel:   WB_ALU,
    mem_re:   1'b0,
    mem_we:   1'b0,
    mem_size: 3'd0,
    branch:   1'b0,
    jal:      1'b0,
    jalr:     1'b0,
    illegal:  1'b0
  };

  // Source-register usage by format; U and J formats read no registers.
  function automatic logic reads_rs1(input logic [6:0] opcode);
    return opcode inside {OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JALR};
  endfunction

  function automatic logic reads_rs2(input logic [6:0] opcode);
    return opcode inside {OPC_OP, OPC_STORE, OPC_BRANCH};
  endfunction

endpackage

// File: rtl/otter_decode_stage_if.sv
// IF->ID handshake: fetch (master) offers an instruction, decode (slave)
// answers with if_ready.
interface otter_decode_stage_if;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;

  modport master (output if_valid, output if_instr, output if_pc, input if_ready);
  modport slave  (input if_valid, input if_instr, input if_pc, output if_ready);
endinterface

// File: rtl/otter_imm_gen.sv
// Purely combinational RV32I immediate extraction for every format.
// The opcode bits [6:0] carry no immediate information and are not taken.
module otter_imm_gen (
  input  logic [31:7] instr,
  output logic [31:0] imm_i,
  output logic [31:0] imm_s,
  output logic [31:0] imm_b,
  output logic [31:0] imm_u,
  output logic [31:0] imm_j
);
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'h000};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
endmodule

// File: rtl/otter_decode_stage.sv
// OTTER decode stage: RV32I decoder feeding the ID/EX register, with
// load-use stall, execute back-pressure and flush handling.
module otter_decode_stage
  import otter_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  otter_decode_stage_if.slave         fetch,
  input  logic                        flush,
  input  logic                        ex_stall,
  output logic                        id_valid,
  output logic [31:0]                 id_pc,
  output logic [3:0]                  id_alu_fun,
  output logic [1:0]                  id_op1_sel,
  output logic                        id_op2_sel,
  output logic [31:0]                 id_imm,
  output logic [4:0]                  id_rs1,
  output logic [4:0]                  id_rs2,
  output logic [4:0]                  id_rd,
  output logic                        id_reg_we,
  output logic [1:0]                  id_wb_sel,
  output logic                        id_mem_re,
  output logic                        id_mem_we,
  output logic [2:0]                  id_mem_size,
  output logic                        id_branch,
  output logic                        id_jal,
  output logic                        id_jalr,
  output logic                        id_illegal
);

  id_reg_t     id_q;
  id_reg_t     id_d;
  id_reg_t     dec;
  logic        legal;
  logic        load_use;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  assign instr  = fetch.if_instr;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  otter_imm_gen u_imm_gen (
    .instr (instr[31:7]),
    .imm_i (imm_i),
    .imm_s (imm_s),
    .imm_b (imm_b),
    .imm_u (imm_u),
    .imm_j (imm_j)
  );

  // The hazard looks at if_instr regardless of if_valid so if_ready never
  // depends on the valid it qualifies.
  assign load_use = id_q.valid && id_q.mem_re && (id_q.rd != 5'd0) &&
                    ((reads_rs1(opcode) && (instr[19:15] == id_q.rd)) ||
                     (reads_rs2(opcode) && (instr[24:20] == id_q.rd)));

  assign fetch.if_ready = flush || (!ex_stall && !load_use);

  always_comb begin
    dec       = ID_BUBBLE;
    legal     = 1'b1;
    dec.valid = 1'b1;
    dec.pc    = fetch.if_pc;
    dec.rs1   = instr[19:15];
    dec.rs2   = instr[24:20];
    dec.rd    = instr[11:7];

    case (opcode)
      OPC_OP: begin
        legal       = (funct7 == 7'b0000000) ||
                      ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        dec.alu_fun = alu_fun_t'({funct7[5], funct3});
        dec.reg_we  = 1'b1;
      end
      OPC_OP_IMM: begin
        if (funct3 == 3'b001)
          legal = (funct7 == 7'b0000000);
        else if (funct3 == 3'b101)
          legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
        // Only the right shifts borrow funct7[5]; elsewhere it is immediate bits.
        dec.alu_fun = alu_fun_t'({(funct3 == 3'b101) && funct7[5], funct3});
        dec.op2_sel = OP2_IMM;
        dec.imm     = imm_i;
        dec.reg_we  = 1'b1;
      end
      OPC_LUI: begin
        dec.alu_fun = ALU_LUI;
        dec.op1_sel = OP1_UIMM;
        dec.imm     = imm_u;
        dec.reg_we  = 1'b1;
      end
      OPC_AUIPC: begin
        dec.op1_sel = OP1_PC;
        dec.op2_sel = OP2_IMM;
        dec.imm     = imm_u;
        dec.reg_we  = 1'b1;
      end
      OPC_LOAD: begin
        legal        = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        dec.op2_sel  = OP2_IMM;
        dec.imm      = imm_i;
        dec.reg_we   = 1'b1;
        dec.wb_sel   = WB_MEM;
        dec.mem_re   = 1'b1;
        dec.mem_size = funct3;
      end
      OPC_STORE: begin
        legal        = funct3 inside {3'b000, 3'b001, 3'b010};
        dec.op2_sel  = OP2_IMM;
        dec.imm      = imm_s;
        dec.mem_we   = 1'b1;
        dec.mem_size = funct3;
      end
      OPC_BRANCH: begin
        legal       = (funct3 != 3'b010) && (funct3 != 3'b011);
        dec.op1_sel = OP1_PC;
        dec.op2_sel = OP2_IMM;
        dec.imm     = imm_b;
        dec.branch  = 1'b1;
      end
      OPC_JAL: begin
        dec.op1_sel = OP1_PC;
        dec.op2_sel = OP2_IMM;
        dec.imm     = imm_j;
        dec.reg_we  = 1'b1;
        dec.wb_sel  = WB_PC4;
        dec.jal     = 1'b1;
      end
      OPC_JALR: begin
        legal       = (funct3 == 3'b000);
        dec.op2_sel = OP2_IMM;
        dec.imm     = imm_i;
        dec.reg_we  = 1'b1;
        dec.wb_sel  = WB_PC4;
        dec.jalr    = 1'b1;
      end
      default: legal = 1'b0;
    endcase

    if (dec.rd == 5'd0)
      dec.reg_we = 1'b0;

    // Illegal words still travel as valid so execute can trap on them.
    if (!legal) begin
      dec.illegal  = 1'b1;
      dec.alu_fun  = ALU_ADD;
      dec.op1_sel  = OP1_RS1;
      dec.op2_sel  = OP2_RS2;
      dec.imm      = 32'h0;
      dec.reg_we   = 1'b0;
      dec.wb_sel   = WB_ALU;
      dec.mem_re   = 1'b0;
      dec.mem_we   = 1'b0;
      dec.mem_size = 3'd0;
      dec.branch   = 1'b0;
      dec.jal      = 1'b0;
      dec.jalr     = 1'b0;
    end

    if (flush)
      id_d = ID_BUBBLE;
    else if (ex_stall)
      id_d = id_q;
    else if (load_use)
      id_d = ID_BUBBLE;
    else if (fetch.if_valid)
      id_d = dec;
    else
      id_d = ID_BUBBLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      id_q <= ID_BUBBLE;
    else
      id_q <= id_d;
  end

  assign id_valid    = id_q.valid;
  assign id_pc       = id_q.pc;
  assign id_alu_fun  = id_q.alu_fun;
  assign id_op1_sel  = id_q.op1_sel;
  assign id_op2_sel  = id_q.op2_sel;
  assign id_imm      = id_q.imm;
  assign id_rs1      = id_q.rs1;
  assign id_rs2      = id_q.rs2;
  assign id_rd       = id_q.rd;
  assign id_reg_we   = id_q.reg_we;
  assign id_wb_sel   = id_q.wb_sel;
  assign id_mem_re   = id_q.mem_re;
  assign id_mem_we   = id_q.mem_we;
  assign id_mem_size = id_q.mem_size;
  assign id_branch   = id_q.branch;
  assign id_jal      = id_q.jal;
  assign id_jalr     = id_q.jalr;
  assign id_illegal  = id_q.illegal;

endmodule

// File: tb/tb_otter_decode_stage.sv
// Self-checking bench for otter_decode_stage: directed test-plan cases plus a
// randomized stream compared against an instruction-level reference model.
module tb_otter_decode_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [3:0]  alu_fun;
    logic [1:0]  op1_sel;
    logic        op2_sel;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic        mem_re;
    logic        mem_we;
    logic [2:0]  mem_size;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic        illegal;
  } out_t;

  localparam out_t BUBBLE = '0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic ex_stall = 1'b0;

  logic        id_valid, id_op2_sel, id_reg_we, id_mem_re, id_mem_we;
  logic        id_branch, id_jal, id_jalr, id_illegal;
  logic [31:0] id_pc, id_imm;
  logic [3:0]  id_alu_fun;
  logic [1:0]  id_op1_sel, id_wb_sel;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [2:0]  id_mem_size;

  int checks = 0;
  int errors = 0;
  out_t exp_q = BUBBLE;
  out_t act;

  otter_decode_stage_if fif ();

  otter_decode_stage dut (
    .clk         (clk),
    .rst         (rst),
    .fetch       (fif.slave),
    .flush       (flush),
    .ex_stall    (ex_stall),
    .id_valid    (id_valid),
    .id_pc       (id_pc),
    .id_alu_fun  (id_alu_fun),
    .id_op1_sel  (id_op1_sel),
    .id_op2_sel  (id_op2_sel),
    .id_imm      (id_imm),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rd       (id_rd),
    .id_reg_we   (id_reg_we),
    .id_wb_sel   (id_wb_sel),
    .id_mem_re   (id_mem_re),
    .id_mem_we   (id_mem_we),
    .id_mem_size (id_mem_size),
    .id_branch   (id_branch),
    .id_jal      (id_jal),
    .id_jalr     (id_jalr),
    .id_illegal  (id_illegal)
  );

  assign act = {id_valid, id_pc, id_alu_fun, id_op1_sel, id_op2_sel, id_imm, id_rs1, id_rs2, id_rd,
                id_reg_we, id_wb_sel, id_mem_re, id_mem_we, id_mem_size, id_branch, id_jal, id_jalr,
                id_illegal};

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic out_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
    out_t        o;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        ok;
    logic [31:0] ii, is, ib, iu, ij;
    opc = ins[6:0];
    f3  = ins[14:12];
    f7  = ins[31:25];
    ii  = 32'($signed(ins) >>> 20);
    is  = {ii[31:5], ins[11:7]};
    ib  = {is[31:12], ins[7], is[10:1], 1'b0};
    iu  = ins & 32'hFFFF_F000;
    ij  = {ii[31:20], ins[19:12], ins[20], ins[30:21], 1'b0};
    o = '0;
    o.valid = 1'b1;
    o.pc  = pc;
    o.rs1 = ins[19:15];
    o.rs2 = ins[24:20];
    o.rd  = ins[11:7];
    ok = 1'b1;
    case (opc)
      7'h33: begin
        ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        o.alu_fun = {f7[5], f3}; o.reg_we = 1'b1;
      end
      7'h13: begin
        if (f3 == 3'd1) ok = (f7 == 7'h00);
        else if (f3 == 3'd5) ok = (f7 == 7'h00 || f7 == 7'h20);
        o.alu_fun = {(f3 == 3'd5) && f7[5], f3}; o.op2_sel = 1'b1; o.imm = ii; o.reg_we = 1'b1;
      end
      7'h37: begin o.alu_fun = 4'b1001; o.op1_sel = 2'd1; o.imm = iu; o.reg_we = 1'b1; end
      7'h17: begin o.op1_sel = 2'd2; o.op2_sel = 1'b1; o.imm = iu; o.reg_we = 1'b1; end
      7'h03: begin
        ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        o.op2_sel = 1'b1; o.imm = ii; o.reg_we = 1'b1; o.wb_sel = 2'd1; o.mem_re = 1'b1; o.mem_size = f3;
      end
      7'h23: begin
        ok = (f3 <= 3'd2);
        o.op2_sel = 1'b1; o.imm = is; o.mem_we = 1'b1; o.mem_size = f3;
      end
      7'h63: begin
        ok = (f3 != 3'd2 && f3 != 3'd3);
        o.op1_sel = 2'd2; o.op2_sel = 1'b1; o.imm = ib; o.branch = 1'b1;
      end
      7'h6F: begin o.op1_sel = 2'd2; o.op2_sel = 1'b1; o.imm = ij; o.reg_we = 1'b1; o.wb_sel = 2'd2; o.jal = 1'b1; end
      7'h67: begin
        ok = (f3 == 3'd0);
        o.op2_sel = 1'b1; o.imm = ii; o.reg_we = 1'b1; o.wb_sel = 2'd2; o.jalr = 1'b1;
      end
      default: ok = 1'b0;
    endcase
    if (o.rd == 5'd0) o.reg_we = 1'b0;
    if (!ok) begin
      o = '0;
      o.valid = 1'b1; o.pc = pc; o.rs1 = ins[19:15]; o.rs2 = ins[24:20]; o.rd = ins[11:7];
      o.illegal = 1'b1;
    end
    return o;
  endfunction

  function automatic logic ref_ready(input out_t cur, input logic [31:0] ins, input logic fl, input logic st);
    logic [6:0] opc;
    logic src1, src2, hz;
    opc  = ins[6:0];
    src1 = (opc == 7'h33 || opc == 7'h13 || opc == 7'h03 || opc == 7'h23 || opc == 7'h63 || opc == 7'h67);
    src2 = (opc == 7'h33 || opc == 7'h23 || opc == 7'h63);
    hz = cur.valid && cur.mem_re && cur.rd != 5'd0 &&
         ((src1 && ins[19:15] == cur.rd) || (src2 && ins[24:20] == cur.rd));
    return fl || (!st && !hz);
  endfunction

  function automatic out_t ref_next(input out_t cur, input logic v, input logic [31:0] ins,
                                    input logic [31:0] pc, input logic fl, input logic st);
    if (fl) return BUBBLE;
    if (st) return cur;
    if (!ref_ready(cur, ins, fl, st)) return BUBBLE;
    return v ? ref_decode(ins, pc) : BUBBLE;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  opcs [0:8];
    logic [31:0] w;
    opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67};
    w = $urandom;
    if ($urandom_range(0, 9) == 0) return w;
    w[6:0]   = opcs[$urandom_range(0, 8)];
    w[11:7]  = 5'($urandom_range(0, 3));
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    if ((w[6:0] == 7'h33 || w[6:0] == 7'h13) && $urandom_range(0, 7) != 0)
      w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    return w;
  endfunction

  // ---------------- stimulus plumbing ----------------
  task automatic set_in(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic fl, input logic st);
    fif.if_valid = v;
    fif.if_instr = ins;
    fif.if_pc    = pc;
    flush        = fl;
    ex_stall     = st;
    #1;
  endtask

  task automatic tick();
    exp_q = ref_next(exp_q, fif.if_valid, fif.if_instr, fif.if_pc, flush, ex_stall);
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checks++;
    if (act !== BUBBLE) begin
      errors++;
      $display("FAIL reset_state got %h expected %h", act, BUBBLE);
    end
    checks++;
    if (fif.if_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b expected 1", fif.if_ready);
    end
    rst = 1'b0;
    exp_q = BUBBLE;
    $display("txn reset id_valid=%b if_ready=%b", id_valid, fif.if_ready);
  endtask

  task automatic test_decode();
    logic [31:0] ins_t [0:4];
    logic [3:0]  alu_t [0:4];
    ins_t = '{32'h002081B3, 32'h402081B3, 32'h40335293, 32'h123450B7, 32'hFFFFFFFF};
    alu_t = '{4'b0000, 4'b1000, 4'b1101, 4'b1001, 4'b0000};
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, ins_t[i], 32'h100 + 32'(i * 4), 1'b0, 1'b0);
      checks++;
      if (fif.if_ready !== 1'b1) begin
        errors++;
        $display("FAIL decode_ready idx=%0d got %b expected 1", i, fif.if_ready);
      end
      tick();
      checks++;
      if (act !== exp_q) begin
        errors++;
        $display("FAIL decode_model idx=%0d got %h expected %h", i, act, exp_q);
      end
      checks++;
      if (id_alu_fun !== alu_t[i] || id_valid !== 1'b1) begin
        errors++;
        $display("FAIL decode_alu idx=%0d got %b/%b expected %b/1", i, id_alu_fun, id_valid, alu_t[i]);
      end
      $display("txn decode instr=%h pc=%h alu=%b op1=%0d op2=%0d imm=%h rd=%0d we=%b ill=%b",
               ins_t[i], id_pc, id_alu_fun, id_op1_sel, id_op2_sel, id_imm, id_rd, id_reg_we, id_illegal);
      if (i < 2) begin
        checks++;
        if (id_rs1 !== 5'd1 || id_rs2 !== 5'd2 || id_rd !== 5'd3 || id_op2_sel !== 1'b0 || id_reg_we !== 1'b1) begin
          errors++;
          $display("FAIL rtype_fields got rs1=%0d rs2=%0d rd=%0d op2=%b we=%b expected 1 2 3 0 1",
                   id_rs1, id_rs2, id_rd, id_op2_sel, id_reg_we);
        end
      end else if (i == 2) begin
        checks++;
        if (id_op2_sel !== 1'b1 || id_imm[4:0] !== 5'd3 || id_rd !== 5'd5) begin
          errors++;
          $display("FAIL srai_fields got op2=%b shamt=%0d rd=%0d expected 1 3 5", id_op2_sel, id_imm[4:0], id_rd);
        end
      end else if (i == 3) begin
        checks++;
        if (id_op1_sel !== 2'd1 || id_imm !== 32'h12345000) begin
          errors++;
          $display("FAIL lui_fields got op1=%0d imm=%h expected 1 12345000", id_op1_sel, id_imm);
        end
      end else begin
        checks++;
        if (id_illegal !== 1'b1 || id_reg_we !== 1'b0 || id_mem_we !== 1'b0 || id_mem_re !== 1'b0 ||
            id_branch !== 1'b0 || id_jal !== 1'b0 || id_jalr !== 1'b0) begin
          errors++;
          $display("FAIL illegal_fields got ill=%b we=%b mwe=%b mre=%b br=%b jal=%b jalr=%b expected 1 0 0 0 0 0 0",
                   id_illegal, id_reg_we, id_mem_we, id_mem_re, id_branch, id_jal, id_jalr);
        end
      end
    end
  endtask

  task automatic test_load_use(input logic [31:0] lw_ins, input logic expect_stall);
    int low_cycles = 0;
    set_in(1'b1, lw_ins, 32'h200, 1'b0, 1'b0);
    tick();
    checks++;
    if (act !== exp_q || id_mem_re !== 1'b1) begin
      errors++;
      $display("FAIL lw_issue got %h expected %h", act, exp_q);
    end
    set_in(1'b1, 32'h00528333, 32'h204, 1'b0, 1'b0);
    for (int c = 0; c < 3 && fif.if_ready !== 1'b1; c++) begin
      low_cycles++;
      tick();
      checks++;
      if (act !== BUBBLE) begin
        errors++;
        $display("FAIL load_use_bubble got %h expected %h", act, BUBBLE);
      end
    end
    checks++;
    if (low_cycles != (expect_stall ? 1 : 0)) begin
      errors++;
      $display("FAIL load_use_stall_len got %0d expected %0d", low_cycles, expect_stall ? 1 : 0);
    end
    tick();
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h204 || id_rd !== 5'd6 || act !== exp_q) begin
      errors++;
      $display("FAIL load_use_add got valid=%b pc=%h rd=%0d expected 1 00000204 6", id_valid, id_pc, id_rd);
    end
    $display("txn load_use lw=%h stall_cycles=%0d add_pc=%h", lw_ins, low_cycles, id_pc);
  endtask

  task automatic test_flush_stall();
    set_in(1'b1, 32'h002081B3, 32'h300, 1'b0, 1'b0);
    tick();
    set_in(1'b1, 32'h402081B3, 32'h304, 1'b0, 1'b1);
    checks++;
    if (fif.if_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_ready got %b expected 0", fif.if_ready);
    end
    tick();
    checks++;
    if (id_pc !== 32'h300 || act !== exp_q) begin
      errors++;
      $display("FAIL stall_hold got pc=%h expected 00000300", id_pc);
    end
    set_in(1'b1, 32'h402081B3, 32'h304, 1'b1, 1'b1);
    checks++;
    if (fif.if_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_stall_ready got %b expected 1", fif.if_ready);
    end
    tick();
    checks++;
    if (act !== BUBBLE) begin
      errors++;
      $display("FAIL flush_stall_bubble got %h expected %h", act, BUBBLE);
    end
    // flush must override a pending load-use hazard without stalling
    set_in(1'b1, 32'h0000A283, 32'h308, 1'b0, 1'b0);
    tick();
    set_in(1'b1, 32'h00528333, 32'h30C, 1'b1, 1'b0);
    checks++;
    if (fif.if_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_hazard_ready got %b expected 1", fif.if_ready);
    end
    tick();
    checks++;
    if (id_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_hazard_bubble got %b expected 0", id_valid);
    end
    $display("txn flush_stall id_valid=%b if_ready=%b", id_valid, fif.if_ready);
  endtask

  task automatic test_reset_mid();
    set_in(1'b1, 32'h123450B7, 32'h400, 1'b0, 1'b0);
    tick();
    checks++;
    if (id_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_valid got %b expected 1", id_valid);
    end
    rst = 1'b1;
    #2;
    checks++;
    if (act !== BUBBLE) begin
      errors++;
      $display("FAIL async_reset got %h expected %h", act, BUBBLE);
    end
    exp_q = BUBBLE;
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    $display("txn reset_mid id_valid=%b", id_valid);
  endtask

  task automatic test_random();
    logic        v, fl, st, held;
    logic [31:0] ins, pc;
    held = 1'b0;
    ins  = 32'h0;
    pc   = 32'h1000;
    for (int c = 0; c < 400; c++) begin
      fl = ($urandom_range(0, 9) == 0);
      st = ($urandom_range(0, 5) == 0);
      if (held) begin
        v = 1'b1;
      end else begin
        ins = rand_instr();
        pc  = pc + 32'd4;
        v   = ($urandom_range(0, 3) != 0);
      end
      set_in(v, ins, pc, fl, st);
      checks++;
      if (fif.if_ready !== ref_ready(exp_q, ins, fl, st)) begin
        errors++;
        $display("FAIL rand_ready cycle=%0d got %b expected %b", c, fif.if_ready, ref_ready(exp_q, ins, fl, st));
      end
      held = v && !fif.if_ready;
      tick();
      checks++;
      if (act !== exp_q) begin
        errors++;
        $display("FAIL rand_out cycle=%0d got %h expected %h", c, act, exp_q);
      end
      $display("txn rand %0d v=%b fl=%b st=%b instr=%h -> valid=%b pc=%h alu=%b ill=%b",
               c, v, fl, st, ins, id_valid, id_pc, id_alu_fun, id_illegal);
    end
  endtask

  initial begin
    fif.if_valid = 1'b0;
    fif.if_instr = 32'h0;
    fif.if_pc    = 32'h0;
    test_reset();
    test_decode();
    test_load_use(32'h0000A283, 1'b1);
    test_load_use(32'h0000A003, 1'b0);
    test_flush_stall();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
